// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared types and helpers for the clock time-setting controller.
//   state_t      : controller state (RUN or editing one of the three fields)
//   *_MAX        : last legal BCD value of each field before wrapping to 00
//   FIELD_*      : bit positions of each field inside blink_mask {hour,min,sec}
//   bcd_inc()    : increments one two-digit BCD field with wrap at a limit
// ---------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEC_MAX  = 8'h59;

  localparam int FIELD_HOUR = 2;
  localparam int FIELD_MIN  = 1;
  localparam int FIELD_SEC  = 0;

  // Two-digit BCD increment. Anything at or above the limit wraps to 00, so
  // a corrupt value captured from the core still lands back in range.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val,
                                         input logic [7:0] max);
    logic [7:0] res;
    if (val >= max) begin
      res = 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises one raw push-button, debounces it and emits a one-cycle pulse
// on each accepted press (debounced rising edge). Releases produce no pulse.
//   clk   : system clock
//   rst   : asynchronous active-high reset (debounced level idles low)
//   key   : raw button, active-high, asynchronous to clk
//   press : one-cycle pulse when the debounced level goes 0 -> 1
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DB_CYC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          press_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= 2'b00;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], key};
      press_reg <= 1'b0;
      // Count consecutive cycles where the synced input disagrees with the
      // accepted level; any agreement (a bounce) clears the count.
      if (sync_reg[1] != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync_reg[1];
          cnt_reg   <= '0;
          press_reg <= sync_reg[1];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/clock_time_set.sv
// ---------------------------------------------------------------------------
// clock_time_set
// Time-setting front end for the clock core. The mode key walks through
// RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN; the inc key bumps the field
// under edit. Leaving SET_SEC fires a one-cycle load with the edited time.
//   clk        : system clock (shared with the clock core)
//   rst        : asynchronous active-high reset
//   key_mode   : raw mode button
//   key_inc    : raw increment button
//   cur_time   : live BCD time {HH,MM,SS} from the core, captured on entry
//   set_time   : edited BCD time, registered copy of the edit register
//   load       : one-cycle pulse, core copies set_time
//   editing    : high in any SET state, pauses the core
//   blink_mask : {hour,min,sec}, 1 blanks that field for this blink phase
// ---------------------------------------------------------------------------
module clock_time_set
  import clock_pkg::*;
#(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_HZ    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        load,
  output logic        editing,
  output logic [2:0]  blink_mask
);

  localparam int DB_CYC = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int HP     = CLK_FREQ / (2 * BLINK_HZ);
  localparam int BW     = (HP > 1) ? $clog2(HP) : 1;
  localparam logic [BW-1:0] HP_LAST = BW'(HP - 1);

  // Bit 0 = mode, bit 1 = inc.
  logic [1:0] key_raw;
  logic [1:0] key_press;
  logic       mode_evt;
  logic       inc_evt;

  assign key_raw = {key_inc, key_mode};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DB_CYC(DB_CYC)
      ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .key  (key_raw[gi]),
        .press(key_press[gi])
      );
    end
  endgenerate

  assign mode_evt = key_press[0];
  assign inc_evt  = key_press[1];

  state_t        state_reg, state_next;
  logic [23:0]   edit_reg, edit_next;
  logic [23:0]   set_time_reg;
  logic          load_reg, load_next;
  logic          editing_reg;
  logic [2:0]    mask_reg, mask_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          phase_reg, phase_next;
  logic          inc_hit;
  logic          blink_restart;

  // Mode is checked first in every state, so a simultaneous inc is dropped.
  always_comb begin
    state_next = state_reg;
    edit_next  = edit_reg;
    load_next  = 1'b0;
    inc_hit    = 1'b0;
    case (state_reg)
      RUN: begin
        if (mode_evt) begin
          edit_next  = cur_time;
          state_next = SET_HOUR;
        end
      end
      SET_HOUR: begin
        if (mode_evt) begin
          state_next = SET_MIN;
        end else if (inc_evt) begin
          edit_next[23:16] = bcd_inc(edit_reg[23:16], HOUR_MAX);
          inc_hit          = 1'b1;
        end
      end
      SET_MIN: begin
        if (mode_evt) begin
          state_next = SET_SEC;
        end else if (inc_evt) begin
          edit_next[15:8] = bcd_inc(edit_reg[15:8], MIN_MAX);
          inc_hit         = 1'b1;
        end
      end
      SET_SEC: begin
        if (mode_evt) begin
          state_next = RUN;
          load_next  = 1'b1;
        end else if (inc_evt) begin
          edit_next[7:0] = bcd_inc(edit_reg[7:0], SEC_MAX);
          inc_hit        = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Blink restarts from the visible phase on any state change or edit so the
  // user sees the newly selected field or value immediately.
  assign blink_restart = (state_next != state_reg) || inc_hit;

  always_comb begin
    blink_cnt_next = '0;
    phase_next     = 1'b0;
    if ((state_next != RUN) && !blink_restart) begin
      if (blink_cnt_reg == HP_LAST) begin
        phase_next = ~phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
        phase_next     = phase_reg;
      end
    end
  end

  always_comb begin
    mask_next = 3'b000;
    case (state_next)
      SET_HOUR: mask_next[FIELD_HOUR] = phase_next;
      SET_MIN:  mask_next[FIELD_MIN]  = phase_next;
      SET_SEC:  mask_next[FIELD_SEC]  = phase_next;
      default:  mask_next = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      edit_reg      <= 24'h000000;
      set_time_reg  <= 24'h000000;
      load_reg      <= 1'b0;
      editing_reg   <= 1'b0;
      mask_reg      <= 3'b000;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      edit_reg      <= edit_next;
      set_time_reg  <= edit_next;
      load_reg      <= load_next;
      editing_reg   <= (state_next != RUN);
      mask_reg      <= mask_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
    end
  end

  assign set_time   = set_time_reg;
  assign load       = load_reg;
  assign editing    = editing_reg;
  assign blink_mask = mask_reg;

endmodule

// File: tb/tb_clock_time_set.sv
// ---------------------------------------------------------------------------
// tb_clock_time_set
// Directed bench for clock_time_set with a short debounce and blink period
// (DB_CYC = 10, HP = 10). Keys are driven on the falling edge and outputs are
// sampled on the falling edge. A key held from falling edge N produces its
// visible effect on state outputs at falling edge N+13 (2 sync + 10 stable
// + 1 FSM register).
// ---------------------------------------------------------------------------
module tb_clock_time_set;

  logic        clk;
  logic        rst;
  logic        key_mode;
  logic        key_inc;
  logic [23:0] cur_time;
  logic [23:0] set_time;
  logic        load;
  logic        editing;
  logic [2:0]  blink_mask;

  int total;
  int bad;

  clock_time_set #(
    .CLK_FREQ   (10_000),
    .DEBOUNCE_MS(1),
    .BLINK_HZ   (500)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .cur_time  (cur_time),
    .set_time  (set_time),
    .load      (load),
    .editing   (editing),
    .blink_mask(blink_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the selected keys for 15 cycles then releases them for 15 cycles,
  // logging what happens around the expected event cycle.
  task automatic press_keys(input  logic [1:0]  which,
                            output int          load_cnt,
                            output logic [23:0] load_time,
                            output logic        load_ed,
                            output logic [2:0]  load_mask,
                            output logic [2:0]  mask13,
                            output logic        ed13,
                            output logic [2:0]  mask_end);
    load_cnt  = 0;
    load_time = 24'hxxxxxx;
    load_ed   = 1'bx;
    load_mask = 3'bxxx;
    mask13    = 3'bxxx;
    ed13      = 1'bx;
    key_mode  = which[0];
    key_inc   = which[1];
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (load) begin
        load_cnt++;
        load_time = set_time;
        load_ed   = editing;
        load_mask = blink_mask;
      end
      if (i == 13) begin
        mask13 = blink_mask;
        ed13   = editing;
      end
      if (i == 15) begin
        key_mode = 1'b0;
        key_inc  = 1'b0;
      end
    end
    mask_end = blink_mask;
    $display("press keys=%b set_time=%h editing=%b mask=%b loads=%0d",
             which, set_time, editing, blink_mask, load_cnt);
  endtask

  initial begin
    int          lc;
    logic [23:0] lt;
    logic        le;
    logic [2:0]  lm;
    logic [2:0]  m13;
    logic        e13;
    logic [2:0]  mend;

    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    cur_time = 24'h235958;

    // Reset state and idle with keys low.
    wait_neg(3);
    chk("reset_outputs", {load, editing, blink_mask, set_time[18:0]}, 24'h0);
    chk("reset_set_time", set_time, 24'h000000);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outputs", {load, editing, blink_mask, 19'h0}, 24'h0);
      chk("idle_set_time", set_time, 24'h000000);
    end
    $display("idle 100 cycles set_time=%h editing=%b", set_time, editing);

    // Bouncy mode press: 6 high, 3 low, then a stable run.
    key_mode = 1'b1;
    wait_neg(6);
    key_mode = 1'b0;
    wait_neg(3);
    chk("bounce_no_event", {23'h0, editing}, 24'h0);
    key_mode = 1'b1;
    wait_neg(12);
    chk("mode_not_yet", {23'h0, editing}, 24'h0);
    wait_neg(1);
    chk("mode_editing", {23'h0, editing}, 24'h1);
    chk("mode_capture", set_time, 24'h235958);
    chk("blink_start", {21'h0, blink_mask}, 24'h0);
    wait_neg(2);
    key_mode = 1'b0;
    wait_neg(7);
    chk("blink_last_off", {21'h0, blink_mask}, 24'h0);
    wait_neg(1);
    chk("blink_on", {21'h0, blink_mask}, 24'h4);
    wait_neg(9);
    chk("blink_last_on", {21'h0, blink_mask}, 24'h4);
    wait_neg(1);
    chk("blink_off_again", {21'h0, blink_mask}, 24'h0);
    chk("no_load_enter", {23'h0, load}, 24'h0);
    $display("enter SET_HOUR set_time=%h mask=%b", set_time, blink_mask);

    // Hour increment 23 -> 00; the inc restarts blink (would be 100 otherwise).
    press_keys(2'b10, lc, lt, le, lm, m13, e13, mend);
    chk("hour_wrap", set_time, 24'h005958);
    chk("inc_blink_reset", {21'h0, m13}, 24'h0);
    chk("inc_no_load", lc, 0);

    // To SET_MIN: minute field blinks.
    press_keys(2'b01, lc, lt, le, lm, m13, e13, mend);
    chk("min_mask", {21'h0, mend}, 24'h2);
    chk("min_no_change", set_time, 24'h005958);

    // Minute increment 59 -> 00.
    press_keys(2'b10, lc, lt, le, lm, m13, e13, mend);
    chk("min_wrap", set_time, 24'h000058);
    chk("min_mask_hold", {21'h0, mend}, 24'h2);

    // To SET_SEC, then 58 -> 59 -> 00.
    press_keys(2'b01, lc, lt, le, lm, m13, e13, mend);
    chk("sec_mask", {21'h0, mend}, 24'h1);
    press_keys(2'b10, lc, lt, le, lm, m13, e13, mend);
    chk("sec_digit", set_time, 24'h000059);
    press_keys(2'b10, lc, lt, le, lm, m13, e13, mend);
    chk("sec_wrap", set_time, 24'h000000);

    // Leave SET_SEC: exactly one load pulse, already out of editing.
    press_keys(2'b01, lc, lt, le, lm, m13, e13, mend);
    chk("load_count", lc, 1);
    chk("load_time", lt, 24'h000000);
    chk("load_editing", {23'h0, le}, 24'h0);
    chk("load_mask", {21'h0, lm}, 24'h0);
    chk("run_editing", {23'h0, editing}, 24'h0);
    chk("run_mask", {21'h0, blink_mask}, 24'h0);

    // Simultaneous mode + inc in SET_MIN: mode wins, minutes untouched.
    cur_time = 24'h123456;
    press_keys(2'b01, lc, lt, le, lm, m13, e13, mend);
    chk("recapture", set_time, 24'h123456);
    press_keys(2'b01, lc, lt, le, lm, m13, e13, mend);
    chk("sim_pre_min", {21'h0, mend}, 24'h2);
    press_keys(2'b11, lc, lt, le, lm, m13, e13, mend);
    chk("sim_state_sec", {21'h0, mend}, 24'h1);
    chk("sim_min_kept", set_time, 24'h123456);
    press_keys(2'b01, lc, lt, le, lm, m13, e13, mend);
    chk("sim_load_count", lc, 1);
    chk("sim_load_time", lt, 24'h123456);

    // Reset mid-edit in SET_MIN with 12:00:00.
    cur_time = 24'h120000;
    press_keys(2'b01, lc, lt, le, lm, m13, e13, mend);
    press_keys(2'b01, lc, lt, le, lm, m13, e13, mend);
    chk("pre_rst_min", {21'h0, mend}, 24'h2);
    chk("pre_rst_time", set_time, 24'h120000);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {load, editing, blink_mask, 19'h0}, 24'h0);
    chk("async_rst_time", set_time, 24'h000000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold", {load, editing, blink_mask, 19'h0}, 24'h0);
    end
    rst = 1'b0;
    lc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load) lc++;
    end
    chk("rst_no_load", lc, 0);
    chk("rst_idle_time", set_time, 24'h000000);
    $display("reset mid-edit set_time=%h editing=%b", set_time, editing);

    cur_time = 24'h081530;
    press_keys(2'b01, lc, lt, le, lm, m13, e13, mend);
    chk("post_rst_capture", set_time, 24'h081530);
    chk("post_rst_editing", {23'h0, editing}, 24'h1);
    chk("post_rst_no_load", lc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
